shift_unit_iter: RTL
====================

Name: shift_unit_iter

Overview:
- Parametrised, multi-mode iterative shifter; successor to the fixed 20-bit registered left-shift in the ALU bit_shifts group.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand.
- Shifts STEP bit positions per clock under a start/busy/done handshake, so the ALU sequencer can trade latency for area.

Parameters:
- WIDTH, 20, operand/result width in bits; must be >= 2.
- STEP, 1, bit positions shifted per clock; must be in 1..WIDTH.
- SHAMT_W, $clog2(WIDTH)+1, shift-amount port width (derived; 6 at WIDTH=20).

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand, captured on accepted start.
- b  in  SHAMT_W  shift amount, captured on accepted start.
- mode  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
- busy  out  1  operation in progress; start ignored while high.
- done  out  1  one-cycle pulse; c valid from this cycle.
- c  out  WIDTH  result; holds its value until the next done or rst.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: c=0, done=0, busy=0, FSM=IDLE. A reset asserted mid-operation aborts it; no done pulse follows.
- FSM states are IDLE, SHIFT and FIN.
- IDLE:
  - On start=1, capture a, mode and b into internal registers and compute eff (see below).
  - Go to FIN if eff=0 or mode is reserved; otherwise go to SHIFT with remaining=eff.
  - busy=1 from the following cycle.
- SHIFT: each clock, shift the working register by s=min(STEP, remaining), then remaining -= s. When remaining reaches 0, go to FIN.
- FIN: c <= working register, done <= 1, busy <= 0, go to IDLE. done is high for exactly one cycle.
- Latency: start sampled at edge k; done and c update at edge k+N+1, where N=ceil(eff/STEP). N=0 gives done at edge k+1.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted at the next edge.
- Effective amount (eff):
  - SLL/SRL/SRA: eff = min(b, WIDTH).
  - ROL/ROR: eff = b mod WIDTH.
  - Reserved modes: c = a (pass-through), latency 1.
- Fill rules:
  - SLL shifts in 0 at the LSB.
  - SRL shifts in 0 at the MSB.
  - SRA shifts in the captured a[WIDTH-1] at the MSB; b >= WIDTH yields all sign bits.
  - Rotates lose no bits.
- Mid-operation inputs: changes to a, b or mode while busy do not affect the running operation. start while busy is dropped, not queued.
- c changes only at a done edge or at rst.

Test Plan:
- WIDTH=20, STEP=1: SLL, a=0x00001, b=4, start at edge k -> busy edges k+1..k+4, done=1 only after edge k+5, c=0x00010.
- SRA, a=0x80000, b=25 -> eff=20, done after edge k+21, c=0xFFFFF. Same stimulus with SRL -> c=0x00000.
- ROR, a=0x00001, b=1 -> c=0x80000. ROL, a=0x80001, b=21 -> eff=1, c=0x00003. SLL with b=0 -> c=a, done after edge k+1.
- WIDTH=20, STEP=4: SLL, a=0x00003, b=10 -> N=3, done after edge k+4, c=0x00C00. Reserved mode 111 with a=0x12345 -> c=0x12345, latency 1.
- Handshake: start pulses while busy are ignored (c unchanged, single done). A new start in the done cycle is accepted; its done follows per the latency formula.
- Reset: assert rst for one cycle mid-SHIFT -> next cycle busy=0, done=0, c=0, no later done. A fresh start after reset completes normally.

Source files
------------

// File: rtl/shift_unit_iter.sv
// Iterative multi-mode shifter: SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand,
// advancing up to STEP bit positions per clock under a start/busy/done handshake.
module shift_unit_iter #(
    parameter int WIDTH   = 20,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [2:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   c
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    localparam logic [2:0] SLL = 3'd0;
    localparam logic [2:0] SRL = 3'd1;
    localparam logic [2:0] SRA = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    localparam logic [SHAMT_W-1:0] WIDTH_W = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_W  = SHAMT_W'(STEP);

    logic [1:0]         state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shifted;
    logic [2:0]         modeReg;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] eff;
    logic [SHAMT_W-1:0] s;
    logic               reserved;

    // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH (all fill bits).
    always_comb begin
        reserved = (mode > ROR);
        case (mode)
            ROL, ROR: eff = b % WIDTH_W;
            default:  eff = (b > WIDTH_W) ? WIDTH_W : b;
        endcase
    end

    always_comb begin
        s = (remaining < STEP_W) ? remaining : STEP_W;
        case (modeReg)
            SLL:     shifted = work << s;
            SRL:     shifted = work >> s;
            SRA:     shifted = $unsigned($signed(work) >>> s);
            ROL:     shifted = (work << s) | (work >> (WIDTH_W - s));
            ROR:     shifted = (work >> s) | (work << (WIDTH_W - s));
            default: shifted = work;
        endcase
    end

    // The MSB of work stays equal to the captured sign bit throughout an SRA,
    // so the arithmetic shift above always fills with the original sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            c         <= '0;
            work      <= '0;
            modeReg   <= SLL;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= a;
                        modeReg   <= mode;
                        remaining <= eff;
                        busy      <= 1'b1;
                        state     <= (reserved || eff == '0) ? FIN : SHIFT;
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - s;
                    if (remaining == s) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    c     <= work;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
